// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - CPU-programmable 16-bit countdown timer with prescaler and IRQ
module countdown_timer #(
  parameter int                       DIVIDER_WIDTH = 15,
  parameter logic [DIVIDER_WIDTH-1:0] INTERVAL      = 15'd24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       irq
);

  logic [15:0]              reload;
  logic [15:0]              count;
  logic [7:0]               snapshot;
  logic [DIVIDER_WIDTH-1:0] divider;
  logic                     auto_reload;
  logic                     irq_en;
  logic                     expired;
  logic                     running;

  logic ctrl_wr;
  logic clear_wr;
  logic tick;
  logic expire;

  assign ctrl_wr  = cpu_wr && (cpu_addr == 2'd2);
  assign clear_wr = cpu_wr && (cpu_addr == 2'd3) && cpu_din[0];
  assign tick     = running && (divider == INTERVAL);
  // A control write in the same cycle swallows the tick, and with it any expiry.
  assign expire   = tick && !ctrl_wr && (count <= 16'd1);
  assign irq      = expired & irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload      <= '0;
      count       <= '0;
      snapshot    <= '0;
      divider     <= '0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      expired     <= 1'b0;
      running     <= 1'b0;
      cpu_dout    <= '0;
    end else begin
      if (cpu_rd) begin
        case (cpu_addr)
          2'd0: begin
            cpu_dout <= count[7:0];
            snapshot <= count[15:8];
          end
          2'd1:    cpu_dout <= snapshot;
          2'd2:    cpu_dout <= {5'b0, irq_en, auto_reload, running};
          default: cpu_dout <= {6'b0, running, expired};
        endcase
      end

      if (cpu_wr && (cpu_addr == 2'd0)) reload[7:0]  <= cpu_din;
      if (cpu_wr && (cpu_addr == 2'd1)) reload[15:8] <= cpu_din;

      if (ctrl_wr) begin
        auto_reload <= cpu_din[1];
        irq_en      <= cpu_din[2];
        running     <= cpu_din[0];
        if (cpu_din[0]) begin
          count   <= reload;
          divider <= '0;
        end
      end else if (running) begin
        if (tick) begin
          divider <= '0;
          if (count > 16'd1) begin
            count <= count - 16'd1;
          end else if (auto_reload) begin
            count <= reload;
          end else begin
            count   <= '0;
            running <= 1'b0;
          end
        end else begin
          divider <= divider + 1'b1;
        end
      end

      // Setting beats clearing when both land on the same edge.
      if (expire) begin
        expired <= 1'b1;
      end else if (clear_wr) begin
        expired <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer against an epoch-based reference model
module tb_countdown_timer;

  localparam int TPER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cpu_addr = '0;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [7:0] cpu_din = '0;
  logic [7:0] cpu_dout;
  logic       irq;

  int vectors = 0;
  int miscompares = 0;

  countdown_timer #(.DIVIDER_WIDTH(15), .INTERVAL(15'd3)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: count derived from the clock count since the last (re)load epoch.
  int          cyc = 0;
  int          m_start = 0;
  logic [15:0] m_rl = '0;
  logic [15:0] m_reload = '0;
  logic [15:0] m_frozen = '0;
  logic        m_running = 0, m_auto = 0, m_irqen = 0, m_expired = 0;
  logic [7:0]  m_dout = '0, m_snap = '0;

  function automatic int per(logic [15:0] r);
    return (r == 0) ? 1 : int'(r);
  endfunction

  function automatic logic [15:0] cur_count();
    int k;
    if (!m_running) return m_frozen;
    k = (cyc - m_start) / TPER;
    return (int'(m_rl) > k) ? 16'(int'(m_rl) - k) : 16'd0;
  endfunction

  task automatic model_edge();
    int n;
    logic [15:0] pc;
    logic expire, ctrl;
    pc  = cur_count();
    n   = cyc + 1;
    cyc = n;
    if (reset) begin
      m_start = n; m_rl = 0; m_reload = 0; m_frozen = 0;
      m_running = 0; m_auto = 0; m_irqen = 0; m_expired = 0;
      m_dout = 0; m_snap = 0;
      return;
    end
    expire = m_running && (n > m_start) && ((n - m_start) % TPER == 0)
             && ((n - m_start) / TPER == per(m_rl));
    ctrl = cpu_wr && (cpu_addr == 2'd2);
    if (cpu_rd) begin
      case (cpu_addr)
        2'd0: begin m_dout = pc[7:0]; m_snap = pc[15:8]; end
        2'd1: m_dout = m_snap;
        2'd2: m_dout = {5'b0, m_irqen, m_auto, m_running};
        default: m_dout = {6'b0, m_running, m_expired};
      endcase
    end
    if (ctrl) begin
      m_auto  = cpu_din[1];
      m_irqen = cpu_din[2];
      if (cpu_din[0]) begin
        m_running = 1; m_start = n; m_rl = m_reload;
      end else begin
        m_running = 0; m_frozen = pc;
      end
    end else if (expire) begin
      if (m_auto) begin
        m_start = n; m_rl = m_reload;
      end else begin
        m_running = 0; m_frozen = 0;
      end
    end
    if (expire && !ctrl) m_expired = 1;
    else if (cpu_wr && cpu_addr == 2'd3 && cpu_din[0]) m_expired = 0;
    if (cpu_wr && cpu_addr == 2'd0) m_reload[7:0]  = cpu_din;
    if (cpu_wr && cpu_addr == 2'd1) m_reload[15:8] = cpu_din;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("irq_model", {15'b0, irq}, {15'b0, m_expired & m_irqen});
    check("dout_model", {8'b0, cpu_dout}, {8'b0, m_dout});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_wr = 1;
    step();
    cpu_wr = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    cpu_addr = a; cpu_rd = 1;
    step();
    cpu_rd = 0;
  endtask

  initial begin
    int last, t;

    // Reset state
    idle(2);
    reset = 0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      check("reset_read", {8'b0, cpu_dout}, 16'h0);
    end
    check("reset_irq", {15'b0, irq}, 16'h0);

    // One-shot: reload 3, start with irq_en
    wr(0, 8'h03); wr(1, 8'h00); wr(2, 8'h05);
    idle(11);
    check("oneshot_early", {15'b0, irq}, 16'h0);
    idle(1);
    check("oneshot_irq", {15'b0, irq}, 16'h1);
    rd(3);
    check("oneshot_status", {8'b0, cpu_dout}, 16'h01);
    rd(0);
    check("oneshot_count", {8'b0, cpu_dout}, 16'h00);
    wr(3, 8'h01);

    // Auto-reload: period 8 clocks, four periods
    wr(0, 8'h02); wr(2, 8'h07);
    last = cyc;
    for (int p = 0; p < 4; p++) begin
      t = 0;
      while (!irq && t < 20) begin idle(1); t++; end
      check("auto_period", 16'(cyc - last), 16'd8);
      last = cyc;
      wr(3, 8'h01);
    end
    rd(2);
    check("auto_ctrl", {8'b0, cpu_dout}, 16'h07);
    wr(2, 8'h00); wr(3, 8'h01);

    // Clear on the expiry edge, then a clear one cycle later
    wr(0, 8'h02); wr(2, 8'h05);
    idle(7);
    wr(3, 8'h01);
    check("collide_set_wins", {15'b0, irq}, 16'h1);
    wr(3, 8'h01);
    check("collide_cleared", {15'b0, irq}, 16'h0);

    // Snapshot of the high byte
    wr(0, 8'h00); wr(1, 8'h01); wr(2, 8'h01);
    rd(0);
    check("snap_lo", {8'b0, cpu_dout}, 16'h00);
    idle(4);
    rd(1);
    check("snap_hi", {8'b0, cpu_dout}, 16'h01);
    rd(0);
    check("snap_live_lo", {8'b0, cpu_dout}, 16'hFF);
    wr(2, 8'h00);

    // Stop freezes count; reload write while running does not disturb it
    wr(3, 8'h01);
    wr(0, 8'h0A); wr(1, 8'h00); wr(2, 8'h01);
    idle(9);
    wr(2, 8'h00);
    rd(0);
    check("stop_count", {8'b0, cpu_dout}, 16'h08);
    idle(20);
    rd(0);
    check("stop_frozen", {8'b0, cpu_dout}, 16'h08);
    wr(2, 8'h05);
    idle(3);
    wr(0, 8'h05);
    idle(2);
    rd(0);
    check("reload_live", {8'b0, cpu_dout}, 16'h09);
    wr(2, 8'h05);
    idle(19);
    check("restart_early", {15'b0, irq}, 16'h0);
    idle(1);
    check("restart_irq", {15'b0, irq}, 16'h1);

    // Reload of zero expires after one tick
    wr(3, 8'h01); wr(0, 8'h00); wr(2, 8'h05);
    idle(3);
    check("zero_early", {15'b0, irq}, 16'h0);
    idle(1);
    check("zero_irq", {15'b0, irq}, 16'h1);

    // Reset in the middle of a countdown
    wr(3, 8'h01); wr(0, 8'h32); wr(2, 8'h05);
    idle(10);
    reset = 1; step(); reset = 0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      check("midreset_read", {8'b0, cpu_dout}, 16'h0);
    end
    check("midreset_irq", {15'b0, irq}, 16'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      cpu_addr = 2'($urandom_range(0, 3));
      cpu_rd   = ($urandom_range(0, 3) == 0);
      cpu_wr   = ($urandom_range(0, 4) == 0);
      case (cpu_addr)
        2'd0:    cpu_din = 8'($urandom_range(0, 5));
        2'd1:    cpu_din = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
        default: cpu_din = 8'($urandom);
      endcase
      step();
    end
    reset = 0; cpu_rd = 0; cpu_wr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
